// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone master bus of wb_cmd_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
               wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Purpose: Wishbone classic single-cycle master driven by a cmd stream, with ack timeout.
// Latency: cyc/stb one cycle after cmd handshake; response one cycle after ack or timeout.
// Backpressure: one command in flight; cmd_ready stays low until the response is taken.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_cmd_master_if.master        bus,
    output logic [7:0]             err_count
);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;

    state_e      state_q,     state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q,       cyc_d;
    logic        we_q,        we_d;
    logic [31:0] adr_q,       adr_d;
    logic [31:0] dat_q,       dat_d;
    logic [3:0]  sel_q,       sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q,   rsp_dat_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q gates acceptance so it is low in the first cycle out of reset
                if (bus.cmd_valid && cmd_ready_q) begin
                    we_d        = bus.cmd_we;
                    adr_d       = bus.cmd_adr;
                    dat_d       = bus.cmd_dat;
                    sel_d       = bus.cmd_sel;
                    cnt_d       = '0;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RSP;
                end else if (cnt_q == LAST_WAIT) begin
                    rsp_dat_d   = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed plus randomized bench for wb_cmd_master with a transaction-level expectation model.
module tb_wb_cmd_master;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] err_count;
    int         total = 0;
    int         bad   = 0;
    int         model_err = 0;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One command end to end. The slave acks on BUS cycle wait_n+1; waits of TO or more never ack.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int wait_n, input logic [31:0] rdata,
                           input int hold);
        int          cycles;
        int          n;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_dat;
        exp_err = (wait_n >= TO);
        exp_cyc = exp_err ? TO : wait_n + 1;
        exp_dat = exp_err ? ERR : (we ? 32'h0 : rdata);
        if (exp_err && model_err < 255) model_err++;

        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = $urandom;
        bus.cmd_dat   = $urandom;
        bus.cmd_sel   = 4'($urandom);
        bus.cmd_we    = ~we;

        cycles = 0;
        while (bus.wbm_cyc_o === 1'b1 && cycles < 100) begin
            cycles++;
            chk("stb", bus.wbm_stb_o, 1);
            chk("adr_stable", bus.wbm_adr_o, adr);
            chk("dat_stable", bus.wbm_dat_o, dat);
            chk("sel_stable", bus.wbm_sel_o, sel);
            chk("we_stable", bus.wbm_we_o, we);
            chk("no_rsp_in_bus", bus.rsp_valid, 0);
            chk("cmd_ready_in_bus", bus.cmd_ready, 0);
            bus.wbm_ack_i = (cycles == wait_n + 1);
            bus.wbm_dat_i = rdata;
            @(negedge clk);
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;
        chk("cyc_len", cycles, exp_cyc);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_dat", bus.rsp_dat, exp_dat);
        chk("rsp_err", bus.rsp_err, exp_err);
        chk("err_count", err_count, model_err);
        chk("adr_after", bus.wbm_adr_o, adr);

        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_dat", bus.rsp_dat, exp_dat);
            chk("hold_err", bus.rsp_err, exp_err);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_cyc", bus.wbm_cyc_o, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_done", bus.rsp_valid, 0);
        chk("cmd_ready_after", bus.cmd_ready, 1);
        chk("cyc_after", bus.wbm_cyc_o, 0);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_stb", bus.wbm_stb_o, 0);
        chk("rst_adr", bus.wbm_adr_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_dat", bus.rsp_dat, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Stray ack while idle
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h1234_5678;
        repeat (2) @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        chk("stray_ack_cyc", bus.wbm_cyc_o, 0);
        chk("stray_ack_rsp", bus.rsp_valid, 0);

        run_cmd(1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF, 0, 32'hDEAD_BEEF, 0);
        run_cmd(1'b0, 32'h3000_0004, 32'h0, 4'h3, 3, 32'h0000_000A, 0);
        run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 99, 32'h5555_5555, 0);
        run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, TO - 1, 32'h0000_0077, 0);
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hC, 1, 32'hCAFE_F00D, 5);

        for (int i = 0; i < 30; i++) begin
            run_cmd(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, TO + 2)), $urandom, int'($urandom_range(0, 3)));
        end

        // Reset mid-cycle: slave never acks, reset lands on the second BUS cycle
        if (model_err == 0) begin
            run_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 99, 32'h0, 0);
        end
        chk("pre_rst_err_nonzero", (err_count != 0), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0040;
        bus.cmd_sel   = 4'hF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rst_bus_cyc_up", bus.wbm_cyc_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", bus.wbm_cyc_o, 0);
        chk("midrst_rsp", bus.rsp_valid, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        rst_n     = 1'b1;
        model_err = 0;
        n = 0;
        repeat (TO + 2) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0) n++;
        end
        chk("midrst_no_response", n, 0);
        run_cmd(1'b1, 32'h3000_0000, 32'h0000_0009, 4'hF, 2, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-cycle bus master that turns a simple valid/ready command stream into read/write cycles toward the user project's Wishbone slave port, and returns each result as a valid/ready response. It is the initiator end of the `wbs_*` interface. It sits beside `user_adder` in test and bring-up builds, so the adder can be exercised from a logic-analyzer or GPIO command source without the management SoC. It bounds every cycle with an ack timeout and reports a timeout as an error response.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum bus cycles to wait for ack (1..65535).
- `ERR_DATA`, default 32'hFFFF_FFFF: `rsp_dat` value returned on timeout.

Ports:
- `wb_clk_i`  in  1  clock; all logic is on the rising edge.
- `wb_rst_ni`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  32  byte address.
- `cmd_dat`  in  32  write data.
- `cmd_sel`  in  4  byte selects.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_dat`  out  32  read data; 0 for writes; `ERR_DATA` on timeout.
- `rsp_err`  out  1  1 = cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone control.
- `wbm_adr_o`  out  32; `wbm_dat_o`  out  32; `wbm_sel_o`  out  4.
- `wbm_ack_i`  in  1; `wbm_dat_i`  in  32.
- `err_count`  out  8  saturating count of timeouts since reset.

## Operation
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch `we`, `adr`, `dat`, `sel` into the `wbm_*` output registers, clear the wait counter, and go to BUS.
- BUS:
  - `wbm_cyc_o` = `wbm_stb_o` = 1 and `cmd_ready` = 0.
  - The wait counter increments each cycle without ack.
  - If `wbm_ack_i` = 1: capture `rsp_dat` (`wbm_dat_i` for reads, 0 for writes), set `rsp_err` = 0, and go to RSP.
  - Else if counter == `TIMEOUT`-1: set `rsp_dat` = `ERR_DATA` and `rsp_err` = 1, increment `err_count` (saturating at 255), and go to RSP.
  - Ack on the final timeout cycle counts as success, not an error.
- RSP:
  - `rsp_valid` = 1, with `cyc`/`stb` low.
  - `rsp_dat` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready` go to IDLE.
- `wbm_ack_i` outside BUS is ignored and has no effect.
- Exactly one outstanding command at a time; no pipelining or bursts.
- `wbm_we_o`, `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` stay constant from BUS entry until the next command is accepted.
- Reset values (all outputs): `cmd_ready`=0 during reset and 1 in the first cycle after; everything else 0, including `rsp_*`, `wbm_*` and `err_count`. State = IDLE.
- Reset asserted mid-cycle (BUS or RSP):
  - `cyc`/`stb` drop at that clock edge.
  - The in-flight command and its response are discarded and no response is produced.
  - `err_count` clears.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Handshake at edge N → `wbm_cyc_o`/`wbm_stb_o` high from N+1.
- Ack sampled high at edge M → `cyc`/`stb` low and `rsp_valid` high from M+1.
- Minimum command-to-response latency is 2 cycles, against a zero-wait slave that acks in the first BUS cycle.
- Timeout: `cyc`/`stb` stay high for exactly `TIMEOUT` cycles, then `rsp_valid` rises on the next cycle.
- `cmd_ready` returns high the cycle after the response handshake.
- Peak throughput is one transaction per 3 cycles.

## Test plan
- Write: cmd `we`=1, `adr`=0x3000_0000, `dat`=0x0000_0005, `sel`=0xF; slave acks in the first BUS cycle → one cyc/stb cycle with those values, then `rsp_valid`=1, `rsp_dat`=0, `rsp_err`=0 two cycles after the handshake.
- Read with 3 wait states: slave returns 0x0000_000A → cyc held 4 cycles, `rsp_dat`=0x0000_000A, `rsp_err`=0; address and selects stable throughout.
- Timeout: `TIMEOUT`=4, slave never acks → cyc high exactly 4 cycles, `rsp_err`=1, `rsp_dat`=0xFFFF_FFFF, `err_count`=1.
- Timeout edge: ack arrives on cycle 4 with `TIMEOUT`=4 → success, `err_count` unchanged.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_dat` stable, `cmd_ready`=0, no new bus cycle starts even with `cmd_valid`=1.
- Reset during BUS: `wb_rst_ni`=0 for 1 cycle → cyc low at that edge, no `rsp_valid`, `err_count`=0, next command executes normally.
